// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: serialises register writes as 16-bit SPI mode-0 frames.
// Optional power-up configuration burst enabled by macro SPI_CFG_AUTO_INIT_EN.
module spi_cfg_sequencer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_GAP    = 4,
    parameter int unsigned MAX_ADDR  = 4,
    parameter logic [7:0]  INIT_DUTY = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       err_addr,
    output logic [7:0] frame_count,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       spi_cs
);
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [6:0] ADDR_MAX = 7'(MAX_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit;
    logic [15:0]      r_shift;

    logic       w_init;
    logic       w_init_more;
    logic [2:0] w_init_idx;
    logic       w_ready_rst;
    logic [6:0] w_addr;
    logic [7:0] w_data;
    logic       w_take;
    logic       w_bad;
    logic       w_div_end;
    logic       w_gap_end;

`ifdef SPI_CFG_AUTO_INIT_EN
    logic       r_init;
    logic [2:0] r_init_idx;

    assign w_init      = r_init;
    assign w_init_idx  = r_init_idx;
    assign w_init_more = r_init && (r_init_idx != 3'd4);
    assign w_ready_rst = 1'b0;

    // Walk addresses 0..4 once per reset; each step advances on frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init     <= 1'b1;
            r_init_idx <= 3'd0;
        end else if (r_state == S_GAP && w_gap_end && r_init) begin
            if (r_init_idx == 3'd4) begin
                r_init <= 1'b0;
            end else begin
                r_init_idx <= r_init_idx + 3'd1;
            end
        end
    end
`else
    assign w_init      = 1'b0;
    assign w_init_idx  = 3'd0;
    assign w_init_more = 1'b0;
    assign w_ready_rst = 1'b1;
`endif

    assign w_addr = w_init ? {4'd0, w_init_idx} : req_addr;
    assign w_data = w_init ? ((w_init_idx == 3'd4) ? INIT_DUTY : 8'h00)
                           : req_data;

    assign w_take    = (r_state == S_IDLE) &&
                       (w_init || (req_valid && req_ready));
    assign w_bad     = !w_init && (req_addr > ADDR_MAX);
    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_gap_end = (r_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 5'd0;
            r_shift     <= 16'h0000;
            req_ready   <= w_ready_rst;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_addr    <= 1'b0;
            frame_count <= 8'h00;
            spi_sclk    <= 1'b0;
            spi_copi    <= 1'b0;
            spi_cs      <= 1'b1;
        end else begin
            done     <= 1'b0;
            err_addr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_take && w_bad) begin
                        err_addr <= 1'b1;
                    end else if (w_take) begin
                        r_shift   <= {1'b1, w_addr, w_data};
                        spi_copi  <= 1'b1;
                        spi_cs    <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_bit     <= 5'd0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (w_div_end) begin
                        r_cnt    <= '0;
                        r_bit    <= r_bit + 5'd1;
                        spi_sclk <= 1'b1;
                        r_state  <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Data moves only on the falling edge, keeping COPI stable while SCLK is high.
                S_HIGH: begin
                    if (w_div_end) begin
                        r_cnt    <= '0;
                        spi_sclk <= 1'b0;
                        if (r_bit == 5'd16) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_shift  <= {r_shift[14:0], 1'b0};
                            spi_copi <= r_shift[14];
                            r_state  <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_cnt    <= '0;
                        spi_cs   <= 1'b1;
                        spi_copi <= 1'b0;
                        r_state  <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt       <= '0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                        req_ready   <= !w_init_more;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: directed requests, expected frames queued at issue,
// decoded from the SPI pins by an independent monitor and compared.
module tb_spi_cfg_sequencer;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 4;
`ifdef SPI_CFG_AUTO_INIT_EN
    localparam int FC_BASE   = 5;
    localparam bit READY_RST = 1'b0;
`else
    localparam int FC_BASE   = 0;
    localparam bit READY_RST = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_addr = 7'd0;
    logic [7:0] req_data = 8'd0;
    logic       busy;
    logic       done;
    logic       err_addr;
    logic [7:0] frame_count;
    logic       spi_sclk;
    logic       spi_copi;
    logic       spi_cs;

    spi_cfg_sequencer #(
        .CLK_DIV  (CLK_DIV),
        .CS_GAP   (CS_GAP),
        .MAX_ADDR (4),
        .INIT_DUTY(8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .busy       (busy),
        .done       (done),
        .err_addr   (err_addr),
        .frame_count(frame_count),
        .spi_sclk   (spi_sclk),
        .spi_copi   (spi_copi),
        .spi_cs     (spi_cs)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    bit allow_trunc = 1'b0;
    int trunc_n  = 0;
    int last_gap = 0;
    int frames_n = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: decodes frames on the pins, independent of the stimulus.
    initial begin : monitor
        logic pcs, psclk, pcopi;
        logic [15:0] sh;
        int nb, low_n, high_n;
        pcs = 1'b1; psclk = 1'b0; pcopi = 1'b0;
        sh = '0; nb = 0; low_n = 0; high_n = 0;
        forever begin
            @(negedge clk);
            if (!spi_cs) begin
                if (pcs) begin
                    last_gap = high_n;
                    high_n = 0; nb = 0; low_n = 0;
                end
                low_n++;
                if (spi_sclk && !psclk) begin
                    sh = {sh[14:0], spi_copi};
                    nb++;
                end
                if (spi_sclk && psclk && spi_copi != pcopi)
                    check("copi_changed_sclk_high", spi_copi, pcopi);
            end else begin
                if (!pcs) begin
                    if (nb == 16) begin
                        frames_n++;
                        check("cs_low_clocks", low_n, 33 * CLK_DIV);
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", sh, 0);
                        end else begin
                            check("frame", sh, exp_q.pop_front());
                        end
                    end else if (allow_trunc) begin
                        trunc_n++;
                    end else begin
                        check("frame_bits", nb, 16);
                    end
                end
                high_n++;
                if (spi_sclk) check("sclk_while_cs_high", spi_sclk, 0);
            end
            pcs = spi_cs; psclk = spi_sclk; pcopi = spi_copi;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, READY_RST);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_addr, 0);
        check("rst_fc", frame_count, 0);
        check("rst_sclk", spi_sclk, 0);
        check("rst_copi", spi_copi, 0);
        check("rst_cs", spi_cs, 1);
        rst = 1'b0;
`ifdef SPI_CFG_AUTO_INIT_EN
        begin
            int n;
            for (int i = 0; i < 5; i++)
                exp_q.push_back({1'b1, 7'(i), (i == 4) ? 8'h80 : 8'h00});
            @(negedge clk);
            check("init_ready_low", req_ready, 0);
            n = 0;
            while (!req_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("init_ready_back", req_ready, 1);
            check("init_done_cycle", done, 1);
            check("init_fc", frame_count, 5);
        end
`else
        @(negedge clk);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [6:0] a, input logic [7:0] d,
                        input bit exp_frame);
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("send_ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        if (exp_frame) exp_q.push_back({1'b1, a, d});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // n counts sampled cycles from the first one after acceptance through done.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", done, 1);
    endtask

    initial begin : stim
        int n, rises;
        logic psclk;
        do_reset();

        // Single write 0x04 <- 0xA5
        send(7'h04, 8'hA5, 1'b1);
        check("t1_busy", busy, 1);
        check("t1_cs_low", spi_cs, 0);
        check("t1_ready_low", req_ready, 0);
        wait_done(n);
        check("t1_done_latency", n, 33 * CLK_DIV + CS_GAP + 1);
        check("t1_ready_at_done", req_ready, 1);
        check("t1_fc", frame_count, FC_BASE + 1);
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        // Back-to-back with req_valid held
        req_valid = 1'b1; req_addr = 7'h00; req_data = 8'hFF;
        exp_q.push_back(16'h80FF);
        @(posedge clk);
        @(negedge clk);
        req_addr = 7'h01; req_data = 8'h0F;
        exp_q.push_back(16'h810F);
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t2_done_with_ready", done, 1);
        check("t2_fc1", frame_count, FC_BASE + 2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t2_accepted", busy, 1);
        check("t2_cs_gap", last_gap, CS_GAP + 1);
        wait_done(n);
        check("t2_fc2", frame_count, FC_BASE + 3);

        // Out-of-range address
        send(7'h05, 8'h55, 1'b0);
        check("t3_err_pulse", err_addr, 1);
        check("t3_cs_high", spi_cs, 1);
        check("t3_ready", req_ready, 1);
        check("t3_busy", busy, 0);
        @(negedge clk);
        check("t3_err_one_cycle", err_addr, 0);
        repeat (20) @(negedge clk);
        check("t3_fc", frame_count, FC_BASE + 3);
        check("t3_no_sclk", spi_sclk, 0);

        // Reset during the 8th SCLK high phase
        allow_trunc = 1'b1;
        send(7'h03, 8'h11, 1'b0);
        rises = 0; psclk = 1'b0; n = 0;
        while (rises < 8 && n < 400) begin
            @(negedge clk);
            if (spi_sclk && !psclk) rises++;
            psclk = spi_sclk;
            n++;
        end
        check("t4_reached_8th_high", rises, 8);
        rst = 1'b1;
        @(negedge clk);
        check("t4_cs", spi_cs, 1);
        check("t4_sclk", spi_sclk, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", req_ready, READY_RST);
        check("t4_no_done", done, 0);
        @(negedge clk);
        allow_trunc = 1'b0;
        check("t4_truncated_frames", trunc_n, 1);
        do_reset();
        send(7'h02, 8'h3C, 1'b1);
        wait_done(n);
        check("t4_fc_after", frame_count, FC_BASE + 1);

        // 256 frames wrap frame_count
        do_reset();
        for (int i = 0; i < 256; i++)
            send(7'(i % 5), 8'(i), 1'b1);
        wait_done(n);
        check("t5_fc_wrap", frame_count, FC_BASE);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
